fifo_wrr_sched: RTL and testbench
=================================

Name: fifo_wrr_sched

Overview:
Weighted round-robin read scheduler that shares one downstream consumer between N_Q first-word-fall-through FIFOs. Each cycle it selects at most one FIFO, pulses that FIFO's r_val, and captures the head word into a single-entry output register with valid/ready handshake. Each queue is served in bursts of up to cfg_weight pops before the scheduler rotates to the next eligible queue. The block sits between a bank of ingress FIFOs and a shared egress datapath.

Parameters:
N_Q, 4, number of FIFOs served (2..16)
DATA_W, 32, width of each FIFO word
WGT_W, 4, width of each per-queue weight field
QID_W, clogb2(N_Q) (min 1), width of queue index (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
q_avail  in  N_Q  per-FIFO data_avail (combinational, fall-through)
q_data  in  N_Q*DATA_W  per-FIFO head word; queue i at bits [i*DATA_W +: DATA_W]
q_pop  out  N_Q  one-hot-or-zero pop strobe, drives FIFO r_val
cfg_weight  in  N_Q*WGT_W  per-queue burst quantum; 0 = queue disabled
out_val  out  1  output register holds a word
out_data  out  DATA_W  popped word
out_qid  out  QID_W  source queue of out_data
out_last  out  1  word is the final pop of its burst
out_rdy  in  1  downstream accepts word when out_val & out_rdy

Behaviour:
- Reset: out_val=0, out_data=0, out_qid=0, out_last=0, q_pop=0, state=IDLE, cur_q=0, credit=0.
- Eligible(i) = q_avail[i] & (weight[i] != 0).
- can_pop = ~out_val | out_rdy (output slot free, or freed this cycle).
- FSM IDLE: search eligible queues round-robin from rr_ptr (rr_ptr, rr_ptr+1, ... wrapping). First hit g is granted if can_pop: q_pop[g]=1, cur_q<=g, credit<=weight[g]-1, rr_ptr<=g+1 mod N_Q. If credit becomes 0 go to (stay) IDLE, else go to BURST. No hit or ~can_pop: no pop, state unchanged.
- FSM BURST: if Eligible(cur_q) & can_pop: pop cur_q, credit<=credit-1; credit-1==0 -> IDLE. If ~Eligible(cur_q) (FIFO drained or weight zeroed): burst ends; same cycle behaves as IDLE search (work-conserving, no bubble). If Eligible but ~can_pop: hold, credit unchanged.
- rr_ptr updates only on a burst start; a burst ended early still advances fairness since rr_ptr already points past cur_q.
- Output register: on pop, out_data<=q_data[g], out_qid<=g, out_last<=(remaining credit==0) | burst ended because FIFO not available next cycle is NOT predicted (out_last reflects credit exhaustion only), out_val<=1. Else if out_rdy, out_val<=0.
- Latency: word popped in cycle t visible on out_data in cycle t+1. Full throughput 1 word/cycle with out_rdy held high.
- At most one q_pop bit set per cycle; never pop when the selected q_avail is 0.
- Weight change mid-burst: new value used only at the next burst load; zero weight on cur_q terminates burst immediately.
- Weight of 1: single pop per grant, pure round robin.
- Reset mid-burst: all state cleared, pending out_val dropped.
- Credit arithmetic WGT_W bits, no wrap: decrement only when nonzero.

Decomposition:
- Shared package/header: state encoding (ST_IDLE, ST_BURST), clogb2 helper.
- One sub-module: rr_pick (N_Q-wide rotating priority encoder: req vector + start pointer -> grant valid + index), reused by other arbiters.

Test Plan:
- N_Q=4, weights all 2, all queues full, out_rdy=1 -> pop order q0,q0,q1,q1,q2,q2,q3,q3,q0; out_last on every second word; one word/cycle.
- Weights {3,1,0,2}, all full -> order q0x3,q1,q3x2,q0x3...; q2 never popped.
- q1 holds 1 word, weight 4 -> single q1 pop, burst ends, q2 granted next cycle with no idle cycle.
- out_rdy low 5 cycles with out_val=1 -> q_pop all 0, out_data/out_qid stable, credit unchanged; resume matches uninterrupted sequence.
- Only q3 eligible, rr_ptr=0 -> wrap search grants q3; next burst search starts at q0.
- rst_n low mid-burst with out_val=1 -> next cycle out_val=0, q_pop=0, restart grants q0 first.

Source files
------------

// File: rtl/fifo_wrr_sched_pkg.sv
// Shared types and helpers for the weighted round-robin FIFO read scheduler.
// Holds the FSM state encoding and the index-width helper used to size queue ids.
package fifo_wrr_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // ceil(log2(n)) with a floor of 1, so a 2-queue build still has a 1-bit index
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wrr_sched_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after start, wrapping; combinational.
// No backpressure; gnt_vld is low when req is empty.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [2*N-1:0] rot;
  logic [IDX_W:0] sum;

  always_comb begin
    rot     = {req, req} >> start;
    sum     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Scan from the far end so the entry nearest to start is written last and wins
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start} + (IDX_W + 1)'(k);
        if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
        gnt_vld = 1'b1;
        gnt_idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wrr_sched.sv
// Weighted round-robin reader for N_Q fall-through FIFOs into one output register.
// Pop in cycle t appears on out_data in t+1; pops stall while out_val & ~out_rdy.
module fifo_wrr_sched
  import fifo_wrr_sched_pkg::*;
#(
  parameter int N_Q    = 4,
  parameter int DATA_W = 32,
  parameter int WGT_W  = 4,
  parameter int QID_W  = clogb2(N_Q)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_Q-1:0]        q_avail,
  input  logic [N_Q*DATA_W-1:0] q_data,
  output logic [N_Q-1:0]        q_pop,
  input  logic [N_Q*WGT_W-1:0]  cfg_weight,
  output logic                  out_val,
  output logic [DATA_W-1:0]     out_data,
  output logic [QID_W-1:0]      out_qid,
  output logic                  out_last,
  input  logic                  out_rdy
);

  state_t            state, state_nxt;
  logic [QID_W-1:0]  cur_q, cur_q_nxt;
  logic [QID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [WGT_W-1:0]  credit, credit_nxt;

  logic [DATA_W-1:0] q_word [N_Q];
  logic [WGT_W-1:0]  wgt    [N_Q];
  logic [N_Q-1:0]    elig;

  logic              can_pop;
  logic              pick_vld;
  logic [QID_W-1:0]  pick_idx;
  logic              pop;
  logic [QID_W-1:0]  pop_q;
  logic              pop_last;

  for (genvar g = 0; g < N_Q; g++) begin : g_unpack
    assign q_word[g] = q_data[g*DATA_W +: DATA_W];
    assign wgt[g]    = cfg_weight[g*WGT_W +: WGT_W];
    assign elig[g]   = q_avail[g] & (|cfg_weight[g*WGT_W +: WGT_W]);
  end

  assign can_pop = ~out_val | out_rdy;

  rr_pick #(
    .N     (N_Q),
    .IDX_W (QID_W)
  ) u_pick (
    .req     (elig),
    .start   (rr_ptr),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    state_nxt  = state;
    cur_q_nxt  = cur_q;
    rr_ptr_nxt = rr_ptr;
    credit_nxt = credit;
    pop        = 1'b0;
    pop_q      = cur_q;
    pop_last   = 1'b0;

    if (rst_n) begin
      if (state == ST_BURST && elig[cur_q]) begin
        // Continue the burst; an output stall simply holds credit
        if (can_pop) begin
          pop        = 1'b1;
          pop_q      = cur_q;
          credit_nxt = (credit != '0) ? credit - WGT_W'(1) : '0;
          pop_last   = (credit_nxt == '0);
          if (credit_nxt == '0) state_nxt = ST_IDLE;
        end
      end else begin
        // A burst whose queue went ineligible falls straight into a new search
        if (state == ST_BURST) begin
          state_nxt  = ST_IDLE;
          credit_nxt = '0;
        end
        if (pick_vld && can_pop) begin
          pop        = 1'b1;
          pop_q      = pick_idx;
          cur_q_nxt  = pick_idx;
          credit_nxt = wgt[pick_idx] - WGT_W'(1);
          pop_last   = (credit_nxt == '0);
          rr_ptr_nxt = (pick_idx == QID_W'(N_Q - 1)) ? '0 : pick_idx + QID_W'(1);
          state_nxt  = pop_last ? ST_IDLE : ST_BURST;
        end
      end
    end
  end

  always_comb begin
    q_pop = '0;
    for (int i = 0; i < N_Q; i++) begin
      if (pop && pop_q == QID_W'(i)) q_pop[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur_q  <= '0;
      rr_ptr <= '0;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      cur_q  <= cur_q_nxt;
      rr_ptr <= rr_ptr_nxt;
      credit <= credit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_qid  <= '0;
      out_last <= 1'b0;
    end else if (pop) begin
      out_val  <= 1'b1;
      out_data <= q_word[pop_q];
      out_qid  <= pop_q;
      out_last <= pop_last;
    end else if (out_rdy) begin
      out_val  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wrr_sched.sv
// Directed bench for fifo_wrr_sched: FIFO model feeds the DUT, expected words are
// queued when stimulus is set up and compared as the DUT hands them downstream.
module tb_fifo_wrr_sched;

  localparam int N_Q    = 4;
  localparam int DATA_W = 32;
  localparam int WGT_W  = 4;
  localparam int QID_W  = 2;

  typedef struct packed {
    logic [QID_W-1:0]  qid;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_Q-1:0]        q_avail;
  logic [N_Q*DATA_W-1:0] q_data;
  logic [N_Q-1:0]        q_pop;
  logic [N_Q*WGT_W-1:0]  cfg_weight;
  logic                  out_val;
  logic [DATA_W-1:0]     out_data;
  logic [QID_W-1:0]      out_qid;
  logic                  out_last;
  logic                  out_rdy;

  logic [DATA_W-1:0] fq [N_Q][$];
  exp_t              sb [$];
  int                ld_seq  [N_Q];
  int                exp_seq [N_Q];
  int                checks   = 0;
  int                failures = 0;
  int                cyc = 0;
  int                n_acc, first_acc, last_acc;
  logic              stall_chk = 1'b0;
  string             tname = "init";

  always #5 clk = ~clk;

  fifo_wrr_sched #(
    .N_Q    (N_Q),
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_avail    (q_avail),
    .q_data     (q_data),
    .q_pop      (q_pop),
    .cfg_weight (cfg_weight),
    .out_val    (out_val),
    .out_data   (out_data),
    .out_qid    (out_qid),
    .out_last   (out_last),
    .out_rdy    (out_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tname, tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < N_Q; i++) begin
      q_avail[i] = (fq[i].size() > 0);
      q_data[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int q, input int n);
    for (int k = 0; k < n; k++) begin
      fq[q].push_back({8'(q), 24'(ld_seq[q])});
      ld_seq[q]++;
    end
    drive_fifo();
  endtask

  task automatic expect_w(input int q, input logic last);
    sb.push_back(exp_t'{qid: QID_W'(q), data: {8'(q), 24'(exp_seq[q])}, last: last});
    exp_seq[q]++;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    cfg_weight = {WGT_W'(w3), WGT_W'(w2), WGT_W'(w1), WGT_W'(w0)};
  endtask

  // One clock: sample at negedge, then apply FIFO pops just after the rising edge
  task automatic step();
    logic [N_Q-1:0] pop_s;
    exp_t e;
    @(negedge clk);
    pop_s = q_pop;
    chk("pop_onehot", 64'($onehot0(q_pop)), 64'(1));
    chk("pop_avail", 64'(q_pop & ~q_avail), 64'(0));
    if (stall_chk) begin
      chk("stall_val", 64'(out_val), 64'(1));
      chk("stall_pop", 64'(q_pop), 64'(0));
      if (sb.size() > 0) begin
        chk("stall_data", 64'(out_data), 64'(sb[0].data));
        chk("stall_qid", 64'(out_qid), 64'(sb[0].qid));
      end
    end
    if (out_val && out_rdy) begin
      if (sb.size() == 0) begin
        chk("extra_word", 64'(out_val), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("qid", 64'(out_qid), 64'(e.qid));
        chk("data", 64'(out_data), 64'(e.data));
        chk("last", 64'(out_last), 64'(e.last));
      end
      if (n_acc == 0) first_acc = cyc;
      last_acc = cyc;
      n_acc++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_Q; i++) begin
      if (pop_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    cyc++;
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    out_rdy = 1'b0;
    cfg_weight = '0;
    sb.delete();
    for (int i = 0; i < N_Q; i++) begin
      fq[i].delete();
      ld_seq[i] = 0;
      exp_seq[i] = 0;
    end
    drive_fifo();
    run(2);
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_qid", 64'(out_qid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_q_pop", 64'(q_pop), 64'(0));
    rst_n = 1'b1;
    n_acc = 0;
    first_acc = 0;
    last_acc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    out_rdy = 1'b0;
    q_avail = '0;
    q_data = '0;
    cfg_weight = '0;

    // All weights 2, all queues loaded: pairs in queue order, one word per cycle
    tname = "w2";
    apply_reset();
    set_w(2, 2, 2, 2);
    for (int q = 0; q < N_Q; q++) load(q, 4);
    out_rdy = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N_Q; q++) begin
        expect_w(q, 1'b0);
        expect_w(q, 1'b1);
      end
    run(20);
    chk("drained", 64'(sb.size()), 64'(0));
    chk("count", 64'(n_acc), 64'(16));
    chk("tput", 64'(last_acc - first_acc), 64'(15));

    // Weights {3,1,0,2}: q2 disabled and never served
    tname = "wmix";
    apply_reset();
    set_w(3, 1, 0, 2);
    load(0, 6); load(1, 2); load(2, 4); load(3, 4);
    out_rdy = 1'b1;
    for (int r = 0; r < 2; r++) begin
      expect_w(0, 1'b0); expect_w(0, 1'b0); expect_w(0, 1'b1);
      expect_w(1, 1'b1);
      expect_w(3, 1'b0); expect_w(3, 1'b1);
    end
    run(20);
    chk("drained", 64'(sb.size()), 64'(0));
    chk("count", 64'(n_acc), 64'(12));
    chk("q2_untouched", 64'(fq[2].size()), 64'(4));

    // q1 runs dry inside its burst; q2 follows with no bubble
    tname = "early_end";
    apply_reset();
    set_w(4, 4, 4, 4);
    load(1, 1); load(2, 2);
    out_rdy = 1'b1;
    expect_w(1, 1'b0); expect_w(2, 1'b0); expect_w(2, 1'b0);
    run(8);
    chk("drained", 64'(sb.size()), 64'(0));
    chk("count", 64'(n_acc), 64'(3));
    chk("tput", 64'(last_acc - first_acc), 64'(2));

    // Five stalled cycles mid-burst leave the sequence unchanged
    tname = "stall";
    apply_reset();
    set_w(3, 3, 3, 3);
    for (int q = 0; q < N_Q; q++) load(q, 3);
    for (int q = 0; q < N_Q; q++) begin
      expect_w(q, 1'b0); expect_w(q, 1'b0); expect_w(q, 1'b1);
    end
    for (int c = 0; c < 25; c++) begin
      out_rdy = !(c >= 2 && c <= 6);
      stall_chk = !out_rdy;
      step();
    end
    stall_chk = 1'b0;
    chk("drained", 64'(sb.size()), 64'(0));
    chk("count", 64'(n_acc), 64'(12));

    // Search from rr_ptr=0 wraps to q3; the next search restarts at q0
    tname = "wrap";
    apply_reset();
    set_w(1, 1, 1, 1);
    out_rdy = 1'b1;
    load(3, 1);
    expect_w(3, 1'b1);
    run(3);
    load(0, 1); load(3, 1);
    expect_w(0, 1'b1); expect_w(3, 1'b1);
    run(4);
    chk("drained", 64'(sb.size()), 64'(0));
    chk("count", 64'(n_acc), 64'(3));

    // Reset in the middle of a q0 burst drops the pending word and restarts at q0
    tname = "mid_reset";
    apply_reset();
    set_w(4, 4, 4, 4);
    load(0, 8); load(1, 4);
    out_rdy = 1'b1;
    expect_w(0, 1'b0);
    run(2);
    rst_n = 1'b0;
    out_rdy = 1'b0;
    #1;
    chk("rst_pop_comb", 64'(q_pop), 64'(0));
    step();
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_q_pop", 64'(q_pop), 64'(0));
    rst_n = 1'b1;
    out_rdy = 1'b1;
    exp_seq[0]++;
    expect_w(0, 1'b0); expect_w(0, 1'b0); expect_w(0, 1'b0); expect_w(0, 1'b1);
    expect_w(1, 1'b0); expect_w(1, 1'b0); expect_w(1, 1'b0); expect_w(1, 1'b1);
    expect_w(0, 1'b0); expect_w(0, 1'b0);
    run(16);
    chk("drained", 64'(sb.size()), 64'(0));
    chk("count", 64'(n_acc), 64'(11));
    chk("q0_empty", 64'(fq[0].size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
